dmi_req_bridge: RTL and testbench

- Replaces the combinational op/addr/data-to-DMI tie-off between the JTAG register chain and the debug module with a buffered, handshaked DMI request/response bridge.
- Accepts update pulses carrying op/addr/data, already synchronised into the DM clock domain. Queues them in a parametrised FIFO and issues one outstanding DMI transaction at a time.
- Captures response data and keeps RISC-V-DTM-style sticky status (busy/failed), cleared by dmireset or dmihardreset.

---
 rtl/dmi_req_bridge.sv | 181 ++++++++++++++++++
 tb/tb_dmi_req_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_bridge.sv
// Buffered, handshaked DMI request/response bridge between the JTAG DMI register and the debug module.
// Optional response timeout enabled by defining DMI_BRIDGE_TIMEOUT_EN.
module dmi_req_bridge #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned FifoDepth     = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             update_i,
  input  logic [1:0]                       op_i,
  input  logic [AddrWidth-1:0]             addr_i,
  input  logic [DataWidth-1:0]             data_i,
  input  logic                             capture_i,
  input  logic                             dmireset_i,
  input  logic                             dmihardreset_i,
  output logic                             dmi_req_valid_o,
  input  logic                             dmi_req_ready_i,
  output logic [1:0]                       dmi_req_op_o,
  output logic [AddrWidth-1:0]             dmi_req_addr_o,
  output logic [DataWidth-1:0]             dmi_req_data_o,
  input  logic                             dmi_resp_valid_i,
  output logic                             dmi_resp_ready_o,
  input  logic [DataWidth-1:0]             dmi_resp_data_i,
  input  logic [1:0]                       dmi_resp_err_i,
  output logic [DataWidth-1:0]             rdata_o,
  output logic [1:0]                       status_o,
  output logic [$clog2(FifoDepth+1)-1:0]   pending_o
);

  localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);
  localparam int unsigned EntryW = 2 + AddrWidth + DataWidth;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t            state;
  logic [EntryW-1:0] mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;
  logic [1:0]        sticky;

  logic              op_valid;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              busy;
  logic              resp_fire;
  logic              timeout_hit;
  logic [1:0]        sticky_base;
  logic [1:0]        sticky_next;
  logic [CntW:0]     pend_sum;

`ifdef DMI_BRIDGE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    op_valid    = (op_i == OpRead) || (op_i == OpWrite);
    sticky_base = dmireset_i ? '0 : sticky;
    full        = (count == CntW'(FifoDepth));
    pop         = (state == IDLE) && (count != '0);
    // A full queue still accepts when the head leaves in the same cycle.
    push        = update_i && op_valid && (sticky_base == '0) && (!full || pop) && !dmihardreset_i;
    drop        = update_i && op_valid && (sticky_base == '0) && full && !pop;
    busy        = (state != IDLE) || (count != '0);
    resp_fire   = (state == WAIT) && dmi_resp_valid_i;
`ifdef DMI_BRIDGE_TIMEOUT_EN
    timeout_hit = (state == WAIT) && !dmi_resp_valid_i && ((tmo_cnt + 1'b1) == TmoW'(TimeoutCycles));
`else
    timeout_hit = 1'b0;
`endif

    sticky_next = sticky_base;
    if (drop)
      sticky_next = 2'd3;
    if (((resp_fire && (dmi_resp_err_i != 2'd0)) || timeout_hit) && (sticky_next == 2'd0))
      sticky_next = 2'd2;
    if (capture_i && busy && (sticky_next == 2'd0))
      sticky_next = 2'd3;

    pend_sum  = {1'b0, count} + (CntW + 1)'(state != IDLE);
    pending_o = pend_sum[CntW] ? '1 : pend_sum[CntW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= {op_i, addr_i, data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      sticky           <= '0;
      status_o         <= '0;
      rdata_o          <= '0;
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      dmi_req_op_o     <= '0;
      dmi_req_addr_o   <= '0;
      dmi_req_data_o   <= '0;
`ifdef DMI_BRIDGE_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else if (dmihardreset_i) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      sticky           <= '0;
      status_o         <= '0;
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      count  <= count + CntW'(push) - CntW'(pop);
      sticky <= sticky_next;
      if (capture_i)
        status_o <= busy ? 2'd3 : sticky_next;

      case (state)
        IDLE: begin
          if (pop) begin
            {dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o} <= mem[rd_ptr];
            dmi_req_valid_o <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (dmi_req_ready_i) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
            state            <= WAIT;
`ifdef DMI_BRIDGE_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
          end
        end
        WAIT: begin
          if (dmi_resp_valid_i) begin
            if ((dmi_resp_err_i == 2'd0) && (dmi_req_op_o == OpRead))
              rdata_o <= dmi_resp_data_i;
            dmi_resp_ready_o <= 1'b0;
            state            <= IDLE;
          end else if (timeout_hit) begin
            dmi_resp_ready_o <= 1'b0;
            state            <= IDLE;
          end
`ifdef DMI_BRIDGE_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_req_bridge.sv
// Scoreboard bench for dmi_req_bridge: expected requests and capture results are queued by the
// stimulus and checked by an independent monitor when the DUT presents them.
module tb_dmi_req_bridge;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          update = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          capture = 1'b0;
  logic          dmireset = 1'b0;
  logic          dmihardreset = 1'b0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic [DW-1:0] resp_data = '0;
  logic [1:0]    resp_err = '0;
  logic [DW-1:0] rdata;
  logic [1:0]    status;
  logic [1:0]    pending;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_req[$];
  logic [63:0] exp_cap[$];
  logic        cap_pending = 1'b0;

  dmi_req_bridge #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .FifoDepth(2),
    .TimeoutCycles(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .update_i(update),
    .op_i(op),
    .addr_i(addr),
    .data_i(data),
    .capture_i(capture),
    .dmireset_i(dmireset),
    .dmihardreset_i(dmihardreset),
    .dmi_req_valid_o(req_valid),
    .dmi_req_ready_i(req_ready),
    .dmi_req_op_o(req_op),
    .dmi_req_addr_o(req_addr),
    .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid),
    .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data),
    .dmi_resp_err_i(resp_err),
    .rdata_o(rdata),
    .status_o(status),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted request and each post-capture status against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cap_pending) begin
        if (exp_cap.size() == 0) begin
          checks++; failures++;
          $display("FAIL capture_unexpected actual=%0h required=none", {status, rdata});
        end else begin
          check("capture", {30'd0, status, rdata}, exp_cap.pop_front());
        end
      end
      cap_pending = capture;
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_unexpected actual=%0h required=none", {req_op, req_addr, req_data});
        end else begin
          check("request", {23'd0, req_op, req_addr, req_data}, exp_req.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit expect_issue);
    update = 1'b1; op = o; addr = a; data = d;
    if (expect_issue)
      exp_req.push_back({23'd0, o, a, d});
    tick();
    update = 1'b0;
  endtask

  task automatic do_capture(input logic [1:0] st, input logic [DW-1:0] rd);
    exp_cap.push_back({30'd0, st, rd});
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  task automatic wait_resp_ready();
    int n = 0;
    while (!resp_ready && n < 20) begin
      tick();
      n++;
    end
    check("resp_ready_wait", {63'd0, resp_ready}, 64'd1);
  endtask

  task automatic serve(input logic [DW-1:0] d, input logic [1:0] e);
    wait_resp_ready();
    resp_valid = 1'b1; resp_data = d; resp_err = e;
    tick();
    resp_valid = 1'b0; resp_err = '0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_resp_ready", {63'd0, resp_ready}, 64'd0);
    check("rst_req_fields", {23'd0, req_op, req_addr, req_data}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_status", {62'd0, status}, 64'd0);
    check("rst_pending", {62'd0, pending}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single READ with minimum issue latency
    req_ready = 1'b1;
    send(2'd1, 7'h11, 32'h0, 1'b1);
    check("lat_n1_valid", {63'd0, req_valid}, 64'd0);
    check("lat_n1_pending", {62'd0, pending}, 64'd1);
    tick();
    check("lat_n2_valid", {63'd0, req_valid}, 64'd1);
    tick();
    tick();
    serve(32'hDEADBEEF, 2'd0);
    check("read_pending_idle", {62'd0, pending}, 64'd0);
    do_capture(2'd0, 32'hDEADBEEF);

    // Overflow: depth 2 with the head stalled in REQ
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'd2, AW'(7'h20 + i), 32'hA0 + i, i < 3);
    check("ovf_pending", {62'd0, pending}, 64'd3);
    do_capture(2'd3, 32'hDEADBEEF);
    send(2'd1, 7'h30, 32'h0, 1'b0);
    check("ovf_ignored_pending", {62'd0, pending}, 64'd3);
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      serve(32'h0, 2'd0);
    tick();
    check("ovf_drained", {62'd0, pending}, 64'd0);
    pulse_dmireset();
    do_capture(2'd0, 32'hDEADBEEF);

    // Error response on WRITE, then dmireset with a same-cycle update
    send(2'd2, 7'h10, 32'h55, 1'b1);
    serve(32'hFFFFFFFF, 2'd2);
    do_capture(2'd2, 32'hDEADBEEF);
    send(2'd1, 7'h12, 32'h0, 1'b0);
    check("err_ignored_pending", {62'd0, pending}, 64'd0);
    dmireset = 1'b1;
    send(2'd1, 7'h13, 32'h0, 1'b1);
    dmireset = 1'b0;
    check("rst_update_pending", {62'd0, pending}, 64'd1);
    serve(32'h12345678, 2'd0);
    tick();
    do_capture(2'd0, 32'h12345678);

    // Capture while waiting for a response
    send(2'd1, 7'h14, 32'h0, 1'b1);
    wait_resp_ready();
    do_capture(2'd3, 32'h12345678);
    serve(32'hCAFEF00D, 2'd0);
    tick();
    do_capture(2'd3, 32'hCAFEF00D);
    pulse_dmireset();
    do_capture(2'd0, 32'hCAFEF00D);

    // Hard reset with the head in REQ and two queued
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(2'd2, AW'(7'h40 + i), 32'hB0 + i, 1'b0);
    check("hr_pending_before", {62'd0, pending}, 64'd3);
    do_capture(2'd3, 32'hCAFEF00D);
    dmihardreset = 1'b1;
    tick();
    dmihardreset = 1'b0;
    check("hr_req_valid", {63'd0, req_valid}, 64'd0);
    check("hr_pending", {62'd0, pending}, 64'd0);
    check("hr_status", {62'd0, status}, 64'd0);
    check("hr_rdata", {32'd0, rdata}, {32'd0, 32'hCAFEF00D});
    req_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      tick();
    do_capture(2'd0, 32'hCAFEF00D);

`ifdef DMI_BRIDGE_TIMEOUT_EN
    begin
      int n = 0;
      send(2'd1, 7'h15, 32'h0, 1'b1);
      wait_resp_ready();
      while (resp_ready && n < 20) begin
        n++;
        tick();
      end
      check("tmo_wait_cycles", 64'(n), 64'd8);
      do_capture(2'd2, 32'hCAFEF00D);
      pulse_dmireset();
      send(2'd1, 7'h16, 32'h0, 1'b1);
      wait_resp_ready();
      for (int i = 0; i < 7; i++)
        tick();
      resp_valid = 1'b1; resp_data = 32'h0BADC0DE;
      tick();
      resp_valid = 1'b0;
      do_capture(2'd0, 32'h0BADC0DE);
    end
`endif

    tick();
    tick();
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("cap_queue_empty", 64'(exp_cap.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
